// File: rtl/regread_pkg.sv
// rtl/regread_pkg.sv - shared constants and FSM state type for the register-read arbiter
package regread_pkg;

   localparam int NREQ   = 4;
   localparam int SEL_W  = 4;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DRIVE   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick among four requesters
module rr_pick
   import regread_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      ptr,
   output logic [NREQ-1:0] grant,
   output logic [1:0]      idx
);

   logic       found;
   logic [1:0] cand;

   // Search from ptr upward, wrapping 3->0; the first set request wins.
   always_comb begin
      grant = '0;
      idx   = ptr;
      found = 1'b0;
      cand  = ptr;
      for (int k = 0; k < NREQ; k++) begin
         cand = ptr + 2'(k);
         if (!found && req[cand]) begin
            found       = 1'b1;
            idx         = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regread_arbiter.sv
// rtl/regread_arbiter.sv - three-state arbiter sharing one external 16:1 register mux
module regread_arbiter #(
   parameter int DATA_W = 32,
   parameter int SEL_W  = 4,
   parameter int NREQ   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*SEL_W-1:0] addr,
   output logic [SEL_W-1:0]      sel,
   input  logic [DATA_W-1:0]     mux_data,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       ack,
   output logic [DATA_W-1:0]     rdata
);
   import regread_pkg::state_t;
   import regread_pkg::IDLE;
   import regread_pkg::DRIVE;
   import regread_pkg::CAPTURE;

   state_t           state;
   logic [1:0]       ptr;
   logic [1:0]       owner;
   logic [NREQ-1:0]  pick_grant;
   logic [1:0]       pick_idx;
   logic [SEL_W-1:0] addr_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_addr
      assign addr_arr[i] = addr[i*SEL_W +: SEL_W];
   end

   rr_pick u_pick (
      .req   (req),
      .ptr   (ptr),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   // One transaction is IDLE (pick, latch address) -> DRIVE (mux settles) -> CAPTURE (ack pulse).
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= 2'd0;
         owner <= 2'd0;
         sel   <= '0;
         gnt   <= '0;
         ack   <= '0;
         rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               ack <= '0;
               if (|req) begin
                  owner <= pick_idx;
                  sel   <= addr_arr[pick_idx];
                  gnt   <= pick_grant;
                  state <= DRIVE;
               end
            end
            DRIVE: begin
               // gnt is the owner's one-hot code, so it doubles as the ack pattern.
               rdata <= mux_data;
               ack   <= gnt;
               gnt   <= '0;
               state <= CAPTURE;
            end
            CAPTURE: begin
               ack   <= '0;
               ptr   <= owner + 2'd1;
               state <= IDLE;
            end
            default: begin
               gnt   <= '0;
               ack   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regread_arbiter.sv
// tb/tb_regread_arbiter.sv - directed and random self-checking bench for regread_arbiter
module tb_regread_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] addr;
   logic [3:0]  sel;
   logic [31:0] mux_data;
   logic [3:0]  gnt;
   logic [3:0]  ack;
   logic [31:0] rdata;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n;
   int prev;
   int pending [4];
   int age     [4];
   logic [3:0] exp_addr [4];

   always #5 clk = ~clk;

   // Mux model: every register reads back as A5A5_000<sel>.
   assign mux_data = 32'hA5A5_0000 | {28'd0, sel};

   regread_arbiter #(.DATA_W(32), .SEL_W(4), .NREQ(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .addr     (addr),
      .sel      (sel),
      .mux_data (mux_data),
      .gnt      (gnt),
      .ack      (ack),
      .rdata    (rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 4'b0000;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_ack(input int limit, output int cnt);
      cnt = 0;
      while (ack == 4'b0000 && cnt < limit) begin
         step();
         cnt++;
      end
   endtask

   initial begin
      rst  = 1'b1;
      req  = 4'b0000;
      addr = 16'h0000;
      @(negedge clk);
      step();
      check("rst_sel",   32'(sel),   32'd0);
      check("rst_gnt",   32'(gnt),   32'd0);
      check("rst_ack",   32'(ack),   32'd0);
      check("rst_rdata", rdata,      32'd0);

      // Single request from requester 0, address 5.
      rst  = 1'b0;
      addr = 16'h0005;
      req  = 4'b0001;
      step();
      check("t1_sel",   32'(sel), 32'd5);
      check("t1_gnt",   32'(gnt), 32'h1);
      check("t1_ack0",  32'(ack), 32'h0);
      step();
      check("t1_ack",   32'(ack), 32'h1);
      check("t1_rdata", rdata,    32'hA5A5_0005);
      check("t1_gnt0",  32'(gnt), 32'h0);
      req = 4'b0000;
      step();
      check("t1_ackoff", 32'(ack), 32'h0);
      check("t1_hold",   rdata,    32'hA5A5_0005);

      // All four held: round-robin 0,1,2,3 with 3-cycle spacing.
      do_reset();
      addr = 16'h3210;
      req  = 4'b1111;
      wait_ack(6, n);
      check("rr_latency", 32'(n), 32'd2);
      prev = cyc;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            step();
            wait_ack(6, n);
            check("rr_spacing", 32'(cyc - prev), 32'd3);
            prev = cyc;
         end
         check("rr_order", 32'(ack), 32'(1 << k));
         check("rr_rdata", rdata, 32'hA5A5_0000 + 32'(k));
      end
      req = 4'b0000;
      step();

      // Serve requester 1 so ptr becomes 2, then 0 must win over 1.
      do_reset();
      addr = 16'h3210;
      req  = 4'b0010;
      wait_ack(6, n);
      check("wrap_pre", 32'(ack), 32'h2);
      req = 4'b0000;
      step();
      req = 4'b0011;
      wait_ack(6, n);
      check("wrap_first",  32'(ack), 32'h1);
      check("wrap_rdata0", rdata,    32'hA5A5_0000);
      req = 4'b0010;
      step();
      wait_ack(6, n);
      check("wrap_second", 32'(ack), 32'h2);
      check("wrap_rdata1", rdata,    32'hA5A5_0001);
      req = 4'b0000;
      step();

      // addr change during DRIVE is ignored.
      addr = 16'h0005;
      req  = 4'b0001;
      step();
      check("addr_sel", 32'(sel), 32'd5);
      addr = 16'h0009;
      step();
      check("addr_ack",   32'(ack), 32'h1);
      check("addr_sel2",  32'(sel), 32'd5);
      check("addr_rdata", rdata,    32'hA5A5_0005);
      req = 4'b0000;
      step();

      // Reset in DRIVE aborts the transaction.
      addr = 16'h0007;
      req  = 4'b0001;
      step();
      check("abort_gnt", 32'(gnt), 32'h1);
      check("abort_sel", 32'(sel), 32'd7);
      rst = 1'b1;
      step();
      check("abort_ack",   32'(ack), 32'h0);
      check("abort_gnt0",  32'(gnt), 32'h0);
      check("abort_sel0",  32'(sel), 32'd0);
      check("abort_rdata", rdata,    32'd0);
      rst = 1'b0;
      step();
      check("abort_regnt", 32'(gnt), 32'h1);
      check("abort_resel", 32'(sel), 32'd7);
      step();
      check("abort_reack", 32'(ack), 32'h1);
      check("abort_redat", rdata,    32'hA5A5_0007);
      req = 4'b0000;
      step();

      // Random traffic with continuous invariant and fairness checks.
      for (int i = 0; i < 4; i++) begin
         pending[i]  = 0;
         age[i]      = 0;
         exp_addr[i] = 4'd0;
      end
      for (int c = 0; c < 360; c++) begin
         step();
         check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
         check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
         check("gnt_ack_excl", 32'((gnt != 4'b0) && (ack != 4'b0)), 32'd0);
         for (int i = 0; i < 4; i++) begin
            if (pending[i] != 0)
               age[i]++;
            if (ack[i]) begin
               check("ack_pending", 32'(pending[i]), 32'd1);
               check("ack_latency", 32'(age[i] <= 12), 32'd1);
               check("ack_rdata", rdata, 32'hA5A5_0000 | {28'd0, exp_addr[i]});
               pending[i] = 0;
               req[i]     = 1'b0;
            end else if (pending[i] == 0 && c < 300 && $urandom_range(3) == 0) begin
               pending[i]       = 1;
               age[i]           = 0;
               exp_addr[i]      = 4'($urandom_range(15));
               addr[i*4 +: 4]   = exp_addr[i];
               req[i]           = 1'b1;
            end
         end
      end
      check("drain", 32'(pending[0] + pending[1] + pending[2] + pending[3]), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
